// File: rtl/tron_pkg.sv
// Shared types and constants for the tron trail arbiter.
// Cell codes stored in the grid RAM, default grid size and the arbiter FSM states.
package tron_pkg;

    localparam int TRON_GRID_W = 160;
    localparam int TRON_GRID_H = 120;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_P1    = 2'd1;
    localparam logic [1:0] CELL_P2    = 2'd2;
    localparam logic [1:0] CELL_WALL  = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RD    = 3'd2,
        CHK   = 3'd3,
        WR    = 3'd4
    } arb_state_t;

endpackage

// File: rtl/tron_trail_arbiter_if.sv
// Bus between the trail arbiter, the two player motion units and the grid RAM.
//
// Handshake: a player raises pN_req together with pN_addr and holds both
// unchanged until pN_gnt pulses for one cycle; the transaction is complete
// in that cycle and req may drop afterwards. clr_start is a one-cycle pulse
// with no acknowledge; clr_busy reports the clear in progress. The RAM side
// has no handshake: mem_rdata is valid one cycle after mem_addr.
interface tron_trail_arbiter_if #(
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 2
);
    logic               clr_start;
    logic               clr_busy;
    logic               p1_req;
    logic [ADDR_W-1:0]  p1_addr;
    logic               p1_gnt;
    logic               p1_crash;
    logic               p2_req;
    logic [ADDR_W-1:0]  p2_addr;
    logic               p2_gnt;
    logic               p2_crash;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_we;
    logic [COLOR_W-1:0] mem_wdata;
    logic [COLOR_W-1:0] mem_rdata;

    // Motion units, round control and the RAM as seen from outside the arbiter
    modport master (
        output clr_start, p1_req, p1_addr, p2_req, p2_addr, mem_rdata,
        input  clr_busy, p1_gnt, p1_crash, p2_gnt, p2_crash,
               mem_addr, mem_we, mem_wdata
    );

    // The arbiter itself
    modport slave (
        input  clr_start, p1_req, p1_addr, p2_req, p2_addr, mem_rdata,
        output clr_busy, p1_gnt, p1_crash, p2_gnt, p2_crash,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/tron_rr_arb2.sv
// Two-way round-robin arbiter. Bit 0 is player 1, bit 1 is player 2.
// The player served last loses the next tie; after reset P2 counts as
// last served so P1 wins the first tie.
module tron_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt_onehot
);
    logic last_p2;

    // Pick a single winner from the current requests
    always_comb begin
        gnt_onehot = 2'b00;
        case (req)
            2'b01:   gnt_onehot = 2'b01;
            2'b10:   gnt_onehot = 2'b10;
            2'b11:   gnt_onehot = last_p2 ? 2'b01 : 2'b10;
            default: gnt_onehot = 2'b00;
        endcase
    end

    // Remember who was served when the owner reports completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_p2 <= 1'b1;
        end else if (advance && (gnt_onehot != 2'b00)) begin
            last_p2 <= gnt_onehot[1];
        end
    end
endmodule

// File: rtl/tron_trail_arbiter.sv
// Trail grid RAM port owner: serialises player trail writes with a
// read-check-write sequence that flags collisions, and clears the grid at
// round start.
// Optional feature: define TRON_BORDER_WALL_EN to make the clear paint the
// outer ring of the grid with WALL cells instead of EMPTY.
// GRID_W*GRID_H must fit in ADDR_W address bits.
module tron_trail_arbiter
    import tron_pkg::*;
#(
    parameter int GRID_W  = TRON_GRID_W,
    parameter int GRID_H  = TRON_GRID_H,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    tron_trail_arbiter_if.slave bus,
    output arb_state_t          dbg_state
);

    localparam int                  NUM_CELLS = GRID_W * GRID_H;
    localparam logic [ADDR_W-1:0]   LAST_CELL = ADDR_W'(NUM_CELLS - 1);
    localparam logic [COLOR_W-1:0]  C_EMPTY   = COLOR_W'(CELL_EMPTY);
    localparam logic [COLOR_W-1:0]  C_P1      = COLOR_W'(CELL_P1);
    localparam logic [COLOR_W-1:0]  C_P2      = COLOR_W'(CELL_P2);

    arb_state_t          state;
    logic [1:0]          win;        // player(s) owning the current transaction
    logic                head_on;    // both players aimed at the same cell
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [COLOR_W-1:0]  wdata_q;
    logic                p1_gnt_q;
    logic                p2_gnt_q;
    logic                p1_crash_q;
    logic                p2_crash_q;
    logic                clr_busy_q;
    logic [ADDR_W-1:0]   clr_cnt;    // cell currently being cleared

    logic [1:0]          arb_req;
    logic [1:0]          arb_gnt;
    logic                arb_adv;
    logic                hit;
    logic                clr_step;
    logic                abort_wr;
    logic [COLOR_W-1:0]  first_code;
    logic [COLOR_W-1:0]  next_code;

    // While a transaction is in flight the arbiter only sees the winner, so
    // its grant in WR names exactly the player being completed.
    assign arb_req  = (state == IDLE) ? {bus.p2_req, bus.p1_req} : win;
    // A head-on serves both players at once, so fairness is left untouched.
    assign arb_adv  = (state == WR) && !head_on && !bus.clr_start;
    assign hit      = head_on || (bus.mem_rdata != '0);
    assign clr_step = (state == CLEAR) && !bus.clr_start && (clr_cnt != LAST_CELL);
    // Outputs are registered; a clear arriving in WR masks the already
    // registered write and grants so the transaction leaves no trace.
    assign abort_wr = (state == WR) && bus.clr_start;

    tron_rr_arb2 u_rr (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (arb_req),
        .advance    (arb_adv),
        .gnt_onehot (arb_gnt)
    );

`ifdef TRON_BORDER_WALL_EN
    localparam int                 COL_W  = $clog2(GRID_W);
    localparam int                 ROW_W  = $clog2(GRID_H);
    localparam logic [COLOR_W-1:0] C_WALL = COLOR_W'(CELL_WALL);

    logic [COL_W-1:0] clr_col;
    logic [COL_W-1:0] nxt_col;
    logic [ROW_W-1:0] clr_row;
    logic [ROW_W-1:0] nxt_row;

    // Coordinates of the cell the clear writes next
    always_comb begin
        nxt_col = clr_col + 1'b1;
        nxt_row = clr_row;
        if (clr_col == COL_W'(GRID_W - 1)) begin
            nxt_col = '0;
            nxt_row = clr_row + 1'b1;
        end
    end

    // Row/column of the cell on the bus, kept in step with clr_cnt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clr_col <= '0;
            clr_row <= '0;
        end else if (bus.clr_start) begin
            clr_col <= '0;
            clr_row <= '0;
        end else if (clr_step) begin
            clr_col <= nxt_col;
            clr_row <= nxt_row;
        end
    end

    assign first_code = C_WALL;
    assign next_code  = ((nxt_row == '0) || (nxt_row == ROW_W'(GRID_H - 1)) ||
                         (nxt_col == '0) || (nxt_col == COL_W'(GRID_W - 1))) ? C_WALL : C_EMPTY;
`else
    assign first_code = C_EMPTY;
    assign next_code  = C_EMPTY;
`endif

    // Main FSM: clear sequence and read-check-write transactions
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            win        <= 2'b00;
            head_on    <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            p1_gnt_q   <= 1'b0;
            p2_gnt_q   <= 1'b0;
            p1_crash_q <= 1'b0;
            p2_crash_q <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_cnt    <= '0;
        end else begin
            p1_gnt_q <= 1'b0;
            p2_gnt_q <= 1'b0;
            if (bus.clr_start) begin
                // Clear wins from any state and restarts from cell 0
                state      <= CLEAR;
                win        <= 2'b00;
                head_on    <= 1'b0;
                clr_busy_q <= 1'b1;
                clr_cnt    <= '0;
                addr_q     <= '0;
                we_q       <= 1'b1;
                wdata_q    <= first_code;
                p1_crash_q <= 1'b0;
                p2_crash_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                        if (arb_gnt != 2'b00) begin
                            state <= RD;
                            if (bus.p1_req && bus.p2_req && (bus.p1_addr == bus.p2_addr)) begin
                                head_on <= 1'b1;
                                win     <= 2'b11;
                            end else begin
                                head_on <= 1'b0;
                                win     <= arb_gnt;
                            end
                            addr_q <= arb_gnt[0] ? bus.p1_addr : bus.p2_addr;
                        end else begin
                            addr_q <= '0;
                        end
                    end
                    RD: begin
                        state <= CHK;
                    end
                    CHK: begin
                        state      <= WR;
                        p1_crash_q <= p1_crash_q | (hit & win[0]);
                        p2_crash_q <= p2_crash_q | (hit & win[1]);
                        we_q       <= !hit;
                        wdata_q    <= hit ? C_EMPTY : (win[0] ? C_P1 : C_P2);
                        p1_gnt_q   <= win[0];
                        p2_gnt_q   <= win[1];
                    end
                    WR: begin
                        state   <= IDLE;
                        win     <= 2'b00;
                        head_on <= 1'b0;
                        addr_q  <= '0;
                        we_q    <= 1'b0;
                        wdata_q <= '0;
                    end
                    CLEAR: begin
                        if (clr_cnt == LAST_CELL) begin
                            state      <= IDLE;
                            clr_busy_q <= 1'b0;
                            addr_q     <= '0;
                            we_q       <= 1'b0;
                            wdata_q    <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                            addr_q  <= clr_cnt + 1'b1;
                            wdata_q <= next_code;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_we    = we_q && !abort_wr;
    assign bus.mem_wdata = abort_wr ? '0 : wdata_q;
    assign bus.p1_gnt    = p1_gnt_q && !abort_wr;
    assign bus.p2_gnt    = p2_gnt_q && !abort_wr;
    assign bus.p1_crash  = p1_crash_q;
    assign bus.p2_crash  = p2_crash_q;
    assign bus.clr_busy  = clr_busy_q;
    assign dbg_state     = state;

endmodule
